// File: rtl/ram_ws_rs_data_banked.sv
// Banked, byte-enabled L1.5 instruction-cache data store.
// Independent fetch read port and refill write port; the array is split into
// NUM_BANKS single-port banks interleaved on the low address bits. A read and
// a write proceed together unless they target the same bank. In that case the
// refill wins, but a starvation counter forces the read through after
// STARVE_MAX consecutive losses. Reads are read-first, with latency 1
// (OUT_REG=0) or 2 (OUT_REG=1).
module ram_ws_rs_data_banked #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_BANKS  = 4,
  parameter int OUT_REG    = 0,
  parameter int STARVE_MAX = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_req,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_gnt,
  output logic                    rd_rvalid,
  output logic [DATA_WIDTH-1:0]   rd_rdata,
  input  logic                    wr_req,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_wdata,
  output logic                    wr_gnt
);

  localparam int NBYTES     = DATA_WIDTH / 8;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int LOG2       = $clog2(NUM_BANKS);
  localparam int BANK_W     = (LOG2 == 0) ? 1 : LOG2;
  localparam int ROW_W      = (ADDR_WIDTH > LOG2) ? ADDR_WIDTH - LOG2 : 1;
  localparam int BANK_DEPTH = DEPTH / NUM_BANKS;
  localparam int CNT_W      = (STARVE_MAX >= 1) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  if (NUM_BANKS < 1 || (NUM_BANKS & (NUM_BANKS - 1)) != 0 || NUM_BANKS > DEPTH) begin : g_bad_banks
    $error("NUM_BANKS must be a power of two in 1..2**ADDR_WIDTH");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve
    $error("STARVE_MAX must be at least 1");
  end

  logic [BANK_W-1:0]     w_rd_bank, w_wr_bank;
  logic [ROW_W-1:0]      w_rd_row, w_wr_row;
  logic                  w_conflict;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_bank_rd [NUM_BANKS];
  logic [DATA_WIDTH-1:0] w_rd_mux;
  logic                  r_v1;
  logic [DATA_WIDTH-1:0] r_d1;

  // Low address bits pick the bank, the remaining bits the row inside it.
  if (LOG2 == 0) begin : g_map_single
    assign w_rd_bank = '0;
    assign w_wr_bank = '0;
    assign w_rd_row  = rd_addr;
    assign w_wr_row  = wr_addr;
  end else if (LOG2 >= ADDR_WIDTH) begin : g_map_word
    assign w_rd_bank = rd_addr;
    assign w_wr_bank = wr_addr;
    assign w_rd_row  = '0;
    assign w_wr_row  = '0;
  end else begin : g_map_split
    assign w_rd_bank = rd_addr[LOG2-1:0];
    assign w_wr_bank = wr_addr[LOG2-1:0];
    assign w_rd_row  = rd_addr[ADDR_WIDTH-1:LOG2];
    assign w_wr_row  = wr_addr[ADDR_WIDTH-1:LOG2];
  end

  // Arbitration: refill wins same-bank conflicts until the read has lost STARVE_MAX times.
  always_comb begin
    w_conflict = rd_req & wr_req & (w_rd_bank == w_wr_bank);
    rd_gnt     = 1'b0;
    wr_gnt     = 1'b0;
    w_cnt_nxt  = r_cnt;
    if (!rst) begin
      if (w_conflict) begin
        if (r_cnt == CNT_MAX) begin
          rd_gnt    = 1'b1;
          w_cnt_nxt = '0;
        end else begin
          wr_gnt    = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end else begin
        rd_gnt = rd_req;
        wr_gnt = wr_req;
        if (rd_req) w_cnt_nxt = '0;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_cnt_nxt;
  end

  // One storage array per bank; only the granted bank sees the byte-enabled write.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] r_mem [BANK_DEPTH];
    logic                  w_wr_en;
    assign w_wr_en = wr_gnt && (w_wr_bank == BANK_W'(b));

    // Byte-lane write on a granted refill to this bank.
    always_ff @(posedge clk) begin
      if (w_wr_en) begin
        for (int unsigned i = 0; i < NBYTES; i++) begin
          if (wr_be[i]) r_mem[w_wr_row][8*i +: 8] <= wr_wdata[8*i +: 8];
        end
      end
    end

    assign w_bank_rd[b] = r_mem[w_rd_row];
  end

  // Select the addressed bank's word for the read port.
  always_comb begin
    w_rd_mux = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (w_rd_bank == BANK_W'(b)) w_rd_mux = w_bank_rd[b];
    end
  end

  // First read stage: capture pre-edge array contents on a granted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
    end else begin
      r_v1 <= rd_gnt;
      if (rd_gnt) r_d1 <= w_rd_mux;
    end
  end

  // rvalid is also masked by rst so a read granted just before reset never reports.
  if (OUT_REG != 0) begin : g_out_reg
    logic                  r_v2;
    logic [DATA_WIDTH-1:0] r_d2;

    // Optional timing stage; data only advances with a valid beat so it holds otherwise.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_v2 <= 1'b0;
        r_d2 <= '0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) r_d2 <= r_d1;
      end
    end

    assign rd_rvalid = r_v2 & ~rst;
    assign rd_rdata  = r_d2;
  end else begin : g_out_direct
    assign rd_rvalid = r_v1 & ~rst;
    assign rd_rdata  = r_d1;
  end

endmodule

// File: tb/tb_ram_ws_rs_data_banked.sv
// Testbench for ram_ws_rs_data_banked: directed steps on a 4-bank, latency-1
// instance, then constrained-random traffic on a 1-bank, latency-2 instance.
// A per-instance reference model predicts grants and queues expected read data.
module tb_ram_ws_rs_data_banked;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;

  // Instance 0: NUM_BANKS=4, OUT_REG=0
  logic         a_rst, a_rd_req, a_rd_gnt, a_rd_rvalid, a_wr_req, a_wr_gnt;
  logic [6:0]   a_rd_addr, a_wr_addr;
  logic [127:0] a_rd_rdata, a_wr_wdata;
  logic [15:0]  a_wr_be;

  // Instance 1: NUM_BANKS=1, OUT_REG=1
  logic         b_rst, b_rd_req, b_rd_gnt, b_rd_rvalid, b_wr_req, b_wr_gnt;
  logic [6:0]   b_rd_addr, b_wr_addr;
  logic [127:0] b_rd_rdata, b_wr_wdata;
  logic [15:0]  b_wr_be;

  ram_ws_rs_data_banked #(.DATA_WIDTH(128), .ADDR_WIDTH(7), .NUM_BANKS(4),
                          .OUT_REG(0), .STARVE_MAX(3)) u_dut0 (
    .clk(clk), .rst(a_rst),
    .rd_req(a_rd_req), .rd_addr(a_rd_addr), .rd_gnt(a_rd_gnt),
    .rd_rvalid(a_rd_rvalid), .rd_rdata(a_rd_rdata),
    .wr_req(a_wr_req), .wr_addr(a_wr_addr), .wr_be(a_wr_be),
    .wr_wdata(a_wr_wdata), .wr_gnt(a_wr_gnt)
  );

  ram_ws_rs_data_banked #(.DATA_WIDTH(128), .ADDR_WIDTH(7), .NUM_BANKS(1),
                          .OUT_REG(1), .STARVE_MAX(3)) u_dut1 (
    .clk(clk), .rst(b_rst),
    .rd_req(b_rd_req), .rd_addr(b_rd_addr), .rd_gnt(b_rd_gnt),
    .rd_rvalid(b_rd_rvalid), .rd_rdata(b_rd_rdata),
    .wr_req(b_wr_req), .wr_addr(b_wr_addr), .wr_be(b_wr_be),
    .wr_wdata(b_wr_wdata), .wr_gnt(b_wr_gnt)
  );

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } rd_t;

  rd_t          q0[$];
  rd_t          q1[$];
  logic [127:0] m_mem [2][128];
  int           m_cnt [2];
  int           m_wait[2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model step for one instance, evaluated mid-cycle.
  task automatic mon(input int d, input int nb, input int lat, input logic rst,
                     input logic rd_req, input logic [6:0] rd_addr, input logic rd_gnt,
                     input logic rd_rvalid, input logic [127:0] rd_rdata,
                     input logic wr_req, input logic [6:0] wr_addr, input logic [15:0] wr_be,
                     input logic [127:0] wr_wdata, input logic wr_gnt);
    rd_t  e;
    int   qs;
    logic conflict, erg, ewg;
    if (rst) begin
      chk("rst_rvalid", rd_rvalid, 0);
      chk("rst_gnts", {rd_gnt, wr_gnt}, 0);
      if (d == 0) q0.delete(); else q1.delete();
      m_cnt[d]  = 0;
      m_wait[d] = 0;
      return;
    end
    qs = (d == 0) ? q0.size() : q1.size();
    if (rd_rvalid) begin
      if (qs == 0) chk("rvalid_spurious", 1, 0);
      else begin
        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk("rdata", rd_rdata, e.data);
        chk("rlatency", cyc, e.cyc);
      end
    end else if (qs != 0) begin
      e = (d == 0) ? q0[0] : q1[0];
      if (e.cyc <= cyc) begin
        chk("rvalid_missing", 0, 1);
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
    conflict = rd_req && wr_req && ((rd_addr % nb) == (wr_addr % nb));
    erg = rd_req;
    ewg = wr_req;
    if (conflict) begin
      if (m_cnt[d] == 3) begin erg = 1'b1; ewg = 1'b0; m_cnt[d] = 0; end
      else begin erg = 1'b0; ewg = 1'b1; m_cnt[d]++; end
    end else if (rd_req) m_cnt[d] = 0;
    if (rd_req || wr_req) begin
      chk("rd_gnt", rd_gnt, erg);
      chk("wr_gnt", wr_gnt, ewg);
    end
    if (rd_req && !rd_gnt) begin
      m_wait[d]++;
      chk("read_wait_bound", m_wait[d] <= 3, 1);
    end else m_wait[d] = 0;
    if (erg) begin
      e.data = m_mem[d][rd_addr];
      e.cyc  = cyc + lat;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (ewg) begin
      for (int i = 0; i < 16; i++)
        if (wr_be[i]) m_mem[d][wr_addr][8*i +: 8] = wr_wdata[8*i +: 8];
    end
  endtask

  always @(negedge clk) begin
    mon(0, 4, 1, a_rst, a_rd_req, a_rd_addr, a_rd_gnt, a_rd_rvalid, a_rd_rdata,
        a_wr_req, a_wr_addr, a_wr_be, a_wr_wdata, a_wr_gnt);
    mon(1, 1, 2, b_rst, b_rd_req, b_rd_addr, b_rd_gnt, b_rd_rvalid, b_rd_rdata,
        b_wr_req, b_wr_addr, b_wr_be, b_wr_wdata, b_wr_gnt);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input logic [6:0] a, input logic [15:0] be, input logic [127:0] d);
    a_wr_req = 1'b1; a_wr_addr = a; a_wr_be = be; a_wr_wdata = d;
    @(negedge clk);
    chk("dir_wr_gnt", a_wr_gnt, 1);
    step();
    a_wr_req = 1'b0;
  endtask

  task automatic rd0(input logic [6:0] a, input logic [127:0] exp);
    a_rd_req = 1'b1; a_rd_addr = a;
    @(negedge clk);
    chk("dir_rd_gnt", a_rd_gnt, 1);
    step();
    a_rd_req = 1'b0;
    @(negedge clk);
    chk("dir_rvalid", a_rd_rvalid, 1);
    chk("dir_rdata", a_rd_rdata, exp);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  localparam logic [127:0] D1 = 128'h0101_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [127:0] D2 = 128'h0202_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;
  localparam logic [127:0] D3 = 128'h0303_DEAD_BEEF_CAFE_F00D_1234_5678_9ABC;
  localparam logic [127:0] D4 = 128'h0404_0F0F_F0F0_1357_2468_ACE0_BDF1_0042;
  localparam logic [127:0] D8 = 128'h0808_FEDC_BA98_7654_3210_0123_4567_89AB;

  initial begin
    bit   sr[5], sw[5], cr[4];
    logic rg, wg;
    sr = '{0, 0, 0, 1, 0};
    sw = '{1, 1, 1, 0, 1};
    cr = '{0, 0, 0, 1};

    a_rst = 1'b1; a_rd_req = 1'b1; a_rd_addr = 7'd5;
    a_wr_req = 1'b1; a_wr_addr = 7'd6; a_wr_be = '1; a_wr_wdata = {16{8'h3C}};
    b_rst = 1'b1; b_rd_req = 1'b0; b_rd_addr = '0;
    b_wr_req = 1'b0; b_wr_addr = '0; b_wr_be = '0; b_wr_wdata = '0;

    // Grants suppressed while reset is held
    repeat (2) begin
      @(negedge clk);
      chk("rst_rd_gnt", a_rd_gnt, 0);
      chk("rst_wr_gnt", a_wr_gnt, 0);
    end
    step();
    a_rst = 1'b0; a_rd_req = 1'b0; a_wr_req = 1'b0;
    @(negedge clk);
    chk("reset_rvalid", a_rd_rvalid, 0);
    chk("reset_rdata", a_rd_rdata, 0);
    step();

    // Basic full-word write and read-back
    wr0(7'h05, '1, {16{8'hA5}});
    rd0(7'h05, {16{8'hA5}});

    // Byte enables
    wr0(7'h10, '1, '0);
    wr0(7'h10, 16'h0003, '1);
    rd0(7'h10, 128'hFFFF);

    // Different banks in the same cycle: both granted, read sees old data
    wr0(7'h01, '1, D1);
    wr0(7'h02, '1, D2);
    a_rd_req = 1'b1; a_rd_addr = 7'h01;
    a_wr_req = 1'b1; a_wr_addr = 7'h02; a_wr_be = '1; a_wr_wdata = D3;
    @(negedge clk);
    chk("nc_rd_gnt", a_rd_gnt, 1);
    chk("nc_wr_gnt", a_wr_gnt, 1);
    step();
    a_rd_req = 1'b0; a_wr_req = 1'b0;
    @(negedge clk);
    chk("nc_rvalid", a_rd_rvalid, 1);
    chk("nc_rdata", a_rd_rdata, D1);
    step();
    rd0(7'h02, D3);

    // Same-bank conflict held for 5 cycles
    wr0(7'h04, '1, D4);
    a_rd_req = 1'b1; a_rd_addr = 7'h04;
    a_wr_req = 1'b1; a_wr_addr = 7'h08; a_wr_be = '1; a_wr_wdata = D8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("starve_rd_gnt", a_rd_gnt, sr[i]);
      chk("starve_wr_gnt", a_wr_gnt, sw[i]);
      if (i == 4) begin
        chk("starve_rvalid", a_rd_rvalid, 1);
        chk("starve_rdata", a_rd_rdata, D4);
      end
      step();
    end
    a_rd_req = 1'b0; a_wr_req = 1'b0;
    @(negedge clk);
    chk("starve_single_pulse", a_rd_rvalid, 0);
    step();
    rd0(7'h08, D8);

    // Reset while a read is in flight; write during reset must not land
    a_rd_req = 1'b1; a_rd_addr = 7'h05;
    @(negedge clk);
    chk("mf_rd_gnt", a_rd_gnt, 1);
    step();
    a_rst = 1'b1; a_rd_addr = 7'h06;
    a_wr_req = 1'b1; a_wr_addr = 7'h05; a_wr_be = '1; a_wr_wdata = '0;
    @(negedge clk);
    chk("mf_rvalid_in_rst", a_rd_rvalid, 0);
    chk("mf_rd_gnt_in_rst", a_rd_gnt, 0);
    chk("mf_wr_gnt_in_rst", a_wr_gnt, 0);
    step();
    a_rst = 1'b0; a_rd_req = 1'b0; a_wr_req = 1'b0;
    @(negedge clk);
    chk("mf_rvalid_after", a_rd_rvalid, 0);
    chk("mf_rdata_after", a_rd_rdata, 0);
    step();
    rd0(7'h05, {16{8'hA5}});

    // Reset clears a partly advanced starvation counter
    a_rd_req = 1'b1; a_rd_addr = 7'h04;
    a_wr_req = 1'b1; a_wr_addr = 7'h08; a_wr_be = '1; a_wr_wdata = D8;
    repeat (2) begin
      @(negedge clk);
      chk("cnt_pre_wr_gnt", a_wr_gnt, 1);
      step();
    end
    a_rst = 1'b1;
    @(negedge clk);
    step();
    a_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cnt_post_rd_gnt", a_rd_gnt, cr[i]);
      chk("cnt_post_wr_gnt", a_wr_gnt, !cr[i]);
      step();
    end
    a_rd_req = 1'b0; a_wr_req = 1'b0;
    repeat (2) begin @(negedge clk); step(); end

    // Single bank, registered output: preload then random traffic
    b_rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b_wr_req = 1'b1; b_wr_addr = 7'(i); b_wr_be = '1;
      b_wr_wdata = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      step();
    end
    b_wr_req = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (!b_rd_req && $urandom_range(0, 3) != 0) begin
        b_rd_req = 1'b1; b_rd_addr = 7'($urandom_range(0, 15));
      end
      if (!b_wr_req && $urandom_range(0, 3) != 0) begin
        b_wr_req = 1'b1; b_wr_addr = 7'($urandom_range(0, 15));
        b_wr_be = 16'($urandom);
        b_wr_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      rg = b_rd_gnt;
      wg = b_wr_gnt;
      step();
      if (rg) b_rd_req = 1'b0;
      if (wg) b_wr_req = 1'b0;
    end
    b_rd_req = 1'b0; b_wr_req = 1'b0;
    repeat (4) begin @(negedge clk); step(); end

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_ws_rs_data_banked.md
Name: ram_ws_rs_data_banked

Overview:
Banked, byte-enabled data store for the L1.5 instruction cache with a separate fetch read port and refill write port. Storage is split into NUM_BANKS single-port banks, interleaved on the low address bits, so a refill write and a fetch read proceed in the same cycle unless they hit the same bank. Same-bank conflicts are arbitrated: refill has priority, and a starvation counter guarantees read progress. It replaces the single-port data array between the L1.5 controller and the refill path, and supports an optional output register for timing.

Parameters:
DATA_WIDTH, 128, word width in bits; multiple of 8.
ADDR_WIDTH, 7, word address width; depth = 2**ADDR_WIDTH.
NUM_BANKS, 4, power of two, 1..2**ADDR_WIDTH; bank = addr[log2(NUM_BANKS)-1:0].
OUT_REG, 0, 0: read latency 1 cycle; 1: read latency 2 cycles.
STARVE_MAX, 3, number of consecutive lost conflicts after which the read wins; >=1.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous reset, active-high.
rd_req  in  1  fetch read request.
rd_addr  in  ADDR_WIDTH  read word address.
rd_gnt  out  1  read accepted this cycle (combinational).
rd_rvalid  out  1  read data valid pulse.
rd_rdata  out  DATA_WIDTH  read data.
wr_req  in  1  refill write request.
wr_addr  in  ADDR_WIDTH  write word address.
wr_be  in  DATA_WIDTH/8  byte enables, bit i covers wdata[8i+7:8i].
wr_wdata  in  DATA_WIDTH  write data.
wr_gnt  out  1  write accepted this cycle (combinational).

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: rd_rvalid=0, rd_rdata=0, starvation counter=0, pipeline valids cleared; array contents not reset. While rst=1: rd_gnt=0, wr_gnt=0, no array write, no rvalid in following cycles; in-flight reads are dropped (no rvalid after rst).
- Conflict = rd_req & wr_req & (rd bank == wr bank). NUM_BANKS=1: every simultaneous request conflicts.
- No conflict: rd_gnt=rd_req, wr_gnt=wr_req.
- Conflict, counter<STARVE_MAX: wr_gnt=1, rd_gnt=0, counter+1.
- Conflict, counter==STARVE_MAX: rd_gnt=1, wr_gnt=0, counter cleared.
- Counter also clears on any cycle where rd_gnt=1; holds when rd_req=0 with no conflict. Counter width clog2(STARVE_MAX+1), never exceeds STARVE_MAX.
- Requesters hold req/addr/data stable until gnt; block does not buffer refused requests.
- Write: on granted cycle, only bytes with wr_be=1 updated at the edge; wr_be=0 grants but changes nothing.
- Read: granted at edge N -> rd_rvalid=1 during cycle N+1 (OUT_REG=0) or N+2 (OUT_REG=1), one pulse per grant; back-to-back grants give back-to-back rvalid. Read returns array contents before the edge (read-first): a same-cycle write to another bank is unaffected; a write granted in an earlier cycle is visible.
- rd_rdata holds last valid value when rd_rvalid=0.
- Out-of-range parameters (NUM_BANKS not power of two, DATA_WIDTH%8!=0) flagged by elaboration-time assertion.

Test Plan:
- Reset then write addr 0x05, be all-1, data 0xA5..A5; read 0x05 -> rd_rvalid one cycle after gnt, rd_rdata=0xA5..A5 (repeat with OUT_REG=1: two cycles).
- Byte enable: write 0x10 all 0x00, then be=16'h0003 data all 0xFF; read -> 0x0000..00FFFF.
- No conflict: rd_addr=0x01, wr_addr=0x02 same cycle (NUM_BANKS=4) -> rd_gnt=1, wr_gnt=1; read returns old 0x01 data.
- Starvation: rd_addr=0x04, wr_addr=0x08 held 5 cycles (STARVE_MAX=3) -> wr_gnt 1,1,1, cycle 4 rd_gnt=1/wr_gnt=0, cycle 5 wr_gnt=1.
- Reset mid-flight: read granted, rst=1 next cycle -> rd_rvalid stays 0, rd_rdata=0, counter=0; gnts 0 during rst.
- NUM_BANKS=1: any simultaneous rd/wr conflicts; 100 random cycles -> scoreboard data match, no read waits more than STARVE_MAX+1 cycles.
